// File: rtl/chacha20_arbiter_if.sv
// Arbiter-to-keystream-core bus: the arbiter is master, the shared chacha20 core is slave.
interface chacha20_arbiter_if;
  logic         core_req;
  logic         core_key_reload;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [31:0]  core_counter;
  logic         core_busy;
  logic [511:0] core_keystream;
  logic         core_keystream_valid;

  modport master (
    output core_req, core_key_reload, core_key, core_nonce, core_counter,
    input  core_busy, core_keystream, core_keystream_valid
  );

  modport slave (
    input  core_req, core_key_reload, core_key, core_nonce, core_counter,
    output core_busy, core_keystream, core_keystream_valid
  );
endinterface

// File: rtl/chacha20_arbiter.sv
// Round-robin arbiter sharing one chacha20 keystream core between C_NUM_REQ requesters,
// with key/nonce reload on owner change and a watchdog that aborts hung blocks.
module chacha20_arbiter #(
  parameter int C_NUM_REQ        = 2,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                     i_aclk,
  input  logic                     i_aresetn,
  input  logic [C_NUM_REQ-1:0]     i_req,
  input  logic [C_NUM_REQ-1:0]     i_key_reload,
  input  logic [C_NUM_REQ*32-1:0]  i_req_counter,
  input  logic [C_NUM_REQ*256-1:0] i_req_key,
  input  logic [C_NUM_REQ*96-1:0]  i_req_nonce,
  output logic [C_NUM_REQ-1:0]     o_req_busy,
  output logic [511:0]             o_keystream,
  output logic [C_NUM_REQ-1:0]     o_keystream_valid,
  output logic [C_NUM_REQ-1:0]     o_error,
  output logic [C_NUM_REQ-1:0]     o_grant,
  chacha20_arbiter_if.master       core
);
  localparam int IW = $clog2(C_NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  logic [C_NUM_REQ-1:0] r_pending;
  logic [C_NUM_REQ-1:0] r_reload_pend;
  logic [C_NUM_REQ-1:0] r_grant;
  logic [C_NUM_REQ-1:0] r_kv;
  logic [C_NUM_REQ-1:0] r_err;
  logic [IW-1:0]        r_gidx;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_last;
  logic                 r_owner_valid;
  logic [15:0]          r_wd;
  logic [511:0]         r_keystream;
  logic                 r_core_req;
  logic                 r_core_reload;
  logic [255:0]         r_core_key;
  logic [95:0]          r_core_nonce;
  logic [31:0]          r_core_counter;

  logic                 w_any;
  logic                 w_found;
  logic [IW-1:0]        w_pick;
  logic [C_NUM_REQ-1:0] w_pick_oh;
  logic [C_NUM_REQ-1:0] w_pend_clr;
  logic [C_NUM_REQ-1:0] w_reload_clr;
  logic                 w_need_load;

  // Round-robin: first pending index strictly after the last served one, wrapping.
  always_comb begin
    w_any   = |r_pending;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      if (!w_found && r_pending[(int'(r_last) + k) % C_NUM_REQ]) begin
        w_pick  = IW'((int'(r_last) + k) % C_NUM_REQ);
        w_found = 1'b1;
      end
    end
  end

  assign w_pick_oh    = C_NUM_REQ'(1) << w_pick;
  assign w_pend_clr   = (r_state == S_IDLE && w_any) ? w_pick_oh : '0;
  assign w_reload_clr = (r_state == S_LOAD) ? r_grant : '0;
  assign w_need_load  = r_reload_pend[w_pick] | (w_pick != r_owner) | ~r_owner_valid;

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state        <= S_IDLE;
      r_pending      <= '0;
      r_reload_pend  <= '1;
      r_grant        <= '0;
      r_kv           <= '0;
      r_err          <= '0;
      r_gidx         <= '0;
      r_owner        <= '0;
      r_last         <= IW'(C_NUM_REQ - 1);
      r_owner_valid  <= 1'b0;
      r_wd           <= '0;
      r_keystream    <= '0;
      r_core_req     <= 1'b0;
      r_core_reload  <= 1'b0;
      r_core_key     <= '0;
      r_core_nonce   <= '0;
      r_core_counter <= '0;
    end else begin
      // New pulses win over the clear issued in the same cycle.
      r_pending     <= (r_pending & ~w_pend_clr) | i_req;
      r_reload_pend <= (r_reload_pend & ~w_reload_clr) | i_key_reload;
      r_core_req    <= 1'b0;
      r_core_reload <= 1'b0;
      r_kv          <= '0;
      r_err         <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant        <= w_pick_oh;
            r_gidx         <= w_pick;
            r_core_key     <= i_req_key[256*int'(w_pick) +: 256];
            r_core_nonce   <= i_req_nonce[96*int'(w_pick) +: 96];
            r_core_counter <= i_req_counter[32*int'(w_pick) +: 32];
            r_state        <= w_need_load ? S_LOAD : S_REQ;
          end
        end
        S_LOAD: begin
          r_core_reload <= 1'b1;
          r_owner       <= r_gidx;
          r_owner_valid <= 1'b1;
          r_state       <= S_REQ;
        end
        S_REQ: begin
          if (!core.core_busy) begin
            r_core_req <= 1'b1;
            r_wd       <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core.core_keystream_valid) begin
            r_keystream <= core.core_keystream;
            r_kv        <= r_grant;
            r_state     <= S_RESP;
          end else if (r_wd == 16'(C_TIMEOUT_CYCLES - 1)) begin
            // Abort drops the request and forces a reload on the next grant.
            r_err         <= r_grant;
            r_owner_valid <= 1'b0;
            r_last        <= r_gidx;
            r_grant       <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_RESP: begin
          r_last  <= r_gidx;
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_busy           = r_pending | (r_grant & {C_NUM_REQ{r_state != S_IDLE}});
  assign o_keystream          = r_keystream;
  assign o_keystream_valid    = r_kv;
  assign o_error              = r_err;
  assign o_grant              = r_grant;
  assign core.core_req        = r_core_req;
  assign core.core_key_reload = r_core_reload;
  assign core.core_key        = r_core_key;
  assign core.core_nonce      = r_core_nonce;
  assign core.core_counter    = r_core_counter;
endmodule

// File: tb/tb_chacha20_arbiter.sv
// Scoreboard bench: requests push expected blocks per requester; a monitor pops on each delivery strobe.
module tb_chacha20_arbiter;
  localparam int N   = 2;
  localparam int LAT = 20;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       req = '0, reload = '0, toReq = '0, toReload = '0;
  logic [31:0]        ctr[N];
  logic [255:0]       key[N];
  logic [95:0]        nonce[N];
  logic [N*32-1:0]    ctrBus;
  logic [N*256-1:0]   keyBus;
  logic [N*96-1:0]    nonceBus;
  logic [N-1:0]       busy, kv, err, grant;
  logic [N-1:0]       toBusy, toKv, toErr, toGrant;
  logic [511:0]       ks, toKs;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ctrBus[32*i +: 32]    = ctr[i];
      keyBus[256*i +: 256]  = key[i];
      nonceBus[96*i +: 96]  = nonce[i];
    end
  end

  chacha20_arbiter_if coreIf();
  chacha20_arbiter_if toIf();

  chacha20_arbiter #(.C_NUM_REQ(N), .C_TIMEOUT_CYCLES(1024)) dut (
    .i_aclk(clk), .i_aresetn(rstn), .i_req(req), .i_key_reload(reload),
    .i_req_counter(ctrBus), .i_req_key(keyBus), .i_req_nonce(nonceBus),
    .o_req_busy(busy), .o_keystream(ks), .o_keystream_valid(kv), .o_error(err),
    .o_grant(grant), .core(coreIf.master)
  );

  chacha20_arbiter #(.C_NUM_REQ(N), .C_TIMEOUT_CYCLES(TO)) dutTo (
    .i_aclk(clk), .i_aresetn(rstn), .i_req(toReq), .i_key_reload(toReload),
    .i_req_counter(ctrBus), .i_req_key(keyBus), .i_req_nonce(nonceBus),
    .o_req_busy(toBusy), .o_keystream(toKs), .o_keystream_valid(toKv), .o_error(toErr),
    .o_grant(toGrant), .core(toIf.master)
  );

  assign toIf.core_busy            = 1'b0;
  assign toIf.core_keystream       = '0;
  assign toIf.core_keystream_valid = 1'b0;

  // Reference keystream: any fixed mix of key, nonce and counter is enough to expose stale or wrong routing.
  function automatic logic [511:0] ksModel(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    logic [511:0] r;
    for (int j = 0; j < 16; j++)
      r[32*j +: 32] = (k[32*(j%8) +: 32] ^ n[32*(j%3) +: 32]) + c * 32'(j + 1) + 32'h61707865 * 32'(j);
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // Core model: latches key/nonce on reload, answers each request after LAT cycles.
  logic         mBusy = 1'b0, mValid = 1'b0, forceBusy = 1'b0;
  logic [511:0] mKs = '0;
  logic [255:0] mKey = '0;
  logic [95:0]  mNonce = '0;
  logic [31:0]  mCtr = '0;
  int           mCnt = 0, reloadCount = 0, reqCount = 0;

  assign coreIf.core_busy            = mBusy | forceBusy;
  assign coreIf.core_keystream       = mKs;
  assign coreIf.core_keystream_valid = mValid;

  always @(posedge clk) begin
    mValid <= 1'b0;
    if (coreIf.core_key_reload) begin
      mKey        <= coreIf.core_key;
      mNonce      <= coreIf.core_nonce;
      reloadCount <= reloadCount + 1;
    end
    if (coreIf.core_req && !mBusy) begin
      mBusy    <= 1'b1;
      mCnt     <= LAT;
      mCtr     <= coreIf.core_counter;
      reqCount <= reqCount + 1;
    end else if (mBusy) begin
      if (mCnt == 1) begin
        mBusy  <= 1'b0;
        mValid <= 1'b1;
        mKs    <= ksModel(mKey, mNonce, mCtr);
      end else begin
        mCnt <= mCnt - 1;
      end
    end
  end

  logic [511:0] expQ0[$], expQ1[$];
  int           delivLog[$];
  int           nCompares = 0, nMiscompares = 0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    nCompares++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic popCheck(input int idx);
    logic [511:0] e;
    if ((idx == 0 ? expQ0.size() : expQ1.size()) == 0) begin
      checkOutput("unexpected_strobe", 512'(kv), 512'(0));
    end else begin
      e = (idx == 0) ? expQ0.pop_front() : expQ1.pop_front();
      checkOutput("ks_data", ks, e);
      delivLog.push_back(idx);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (kv !== '0) begin
        checkOutput("kv_onehot", 512'($onehot(kv)), 512'(1));
        if (kv[0]) popCheck(0);
        if (kv[1]) popCheck(1);
      end
      if (err !== '0) checkOutput("main_error", 512'(err), 512'(0));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] rq, input logic [N-1:0] rl);
    if (rq[0]) expQ0.push_back(ksModel(key[0], nonce[0], ctr[0]));
    if (rq[1]) expQ1.push_back(ksModel(key[1], nonce[1], ctr[1]));
    req    = rq;
    reload = rl;
    @(negedge clk);
    req    = '0;
    reload = '0;
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int c = 0;
    while ((expQ0.size() + expQ1.size()) != 0 && c < maxCycles) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, 512'(expQ0.size() + expQ1.size()), 512'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic waitCoreReq(input string name);
    int c = 0;
    while (coreIf.core_req !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, 512'(coreIf.core_req), 512'(1));
  endtask

  task automatic resetDut();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    expQ0.delete();
    expQ1.delete();
    delivLog.delete();
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int rc, rq, seen, c;
    int d1, d2, d3;
    logic [N-1:0] m, l;
    for (int i = 0; i < N; i++) begin
      ctr[i]   = $urandom;
      key[i]   = rand256();
      nonce[i] = {$urandom, $urandom, $urandom};
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_grant", 512'(grant), 512'(0));
    checkOutput("rst_kv", 512'(kv), 512'(0));
    checkOutput("rst_busy", 512'(busy), 512'(0));
    checkOutput("rst_err", 512'(err), 512'(0));
    checkOutput("rst_ks", ks, 512'(0));
    checkOutput("rst_core_req", 512'(coreIf.core_req), 512'(0));
    checkOutput("rst_core_reload", 512'(coreIf.core_key_reload), 512'(0));
    checkOutput("rst_core_key", 512'(coreIf.core_key), 512'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Single request: latency, reload and frozen operands.
    ctr[0] = 32'd5;
    key[0] = {8{32'hC0DE_0F00}};
    rc = reloadCount;
    applyStimulus(2'b01, 2'b00);
    checkOutput("lat_busy", 512'(busy), 512'(2'b01));
    checkOutput("lat_grant_early", 512'(grant), 512'(0));
    @(negedge clk);
    checkOutput("lat_grant", 512'(grant), 512'(2'b01));
    @(negedge clk);
    checkOutput("lat_reload", 512'(coreIf.core_key_reload), 512'(1));
    checkOutput("lat_req_early", 512'(coreIf.core_req), 512'(0));
    @(negedge clk);
    checkOutput("lat_core_req", 512'(coreIf.core_req), 512'(1));
    checkOutput("lat_counter", 512'(coreIf.core_counter), 512'(5));
    checkOutput("lat_key", 512'(coreIf.core_key), 512'({8{32'hC0DE_0F00}}));
    waitDrain("drain_single", 200);
    checkOutput("single_reloads", 512'(reloadCount - rc), 512'(1));

    // Simultaneous requests after reset, then continuous alternation.
    resetDut();
    rc = reloadCount;
    applyStimulus(2'b11, 2'b00);
    waitDrain("drain_both", 300);
    checkOutput("both_count", 512'(delivLog.size()), 512'(2));
    if (delivLog.size() >= 2) begin
      checkOutput("both_first", 512'(delivLog[0]), 512'(0));
      checkOutput("both_second", 512'(delivLog[1]), 512'(1));
    end
    checkOutput("both_reloads", 512'(reloadCount - rc), 512'(2));
    delivLog.delete();
    for (int k = 0; k < 1000 && delivLog.size() < 6; k++) begin
      m = {expQ1.size() == 0, expQ0.size() == 0};
      if (m != '0) begin
        for (int i = 0; i < N; i++) if (m[i]) ctr[i] = $urandom;
        applyStimulus(m, 2'b00);
      end else begin
        @(negedge clk);
      end
    end
    waitDrain("drain_alt", 300);
    checkOutput("alt_count", 512'(delivLog.size() >= 6), 512'(1));
    for (int k = 0; k < 6 && k < delivLog.size(); k++)
      checkOutput("alt_order", 512'(delivLog[k]), 512'(k % 2));

    // Reload only on owner change or requested reload.
    resetDut();
    rc = reloadCount; applyStimulus(2'b01, 2'b00); waitDrain("drain_a", 200); d1 = reloadCount - rc;
    rc = reloadCount; applyStimulus(2'b01, 2'b00); waitDrain("drain_b", 200); d2 = reloadCount - rc;
    rc = reloadCount; applyStimulus(2'b10, 2'b00); waitDrain("drain_c", 200); d3 = reloadCount - rc;
    checkOutput("reload_first0", 512'(d1), 512'(1));
    checkOutput("reload_again0", 512'(d2), 512'(0));
    checkOutput("reload_then1", 512'(d3), 512'(1));
    applyStimulus(2'b01, 2'b00);
    waitDrain("drain_d", 200);
    rc = reloadCount;
    ctr[0] = ctr[0] + 32'd1;
    applyStimulus(2'b01, 2'b00);
    waitCoreReq("midwait_core_req");
    repeat (3) @(negedge clk);
    key[0] = rand256();
    applyStimulus(2'b00, 2'b01);
    waitDrain("drain_e", 200);
    checkOutput("midwait_no_reload", 512'(reloadCount - rc), 512'(0));
    rc = reloadCount;
    ctr[0] = ctr[0] + 32'd1;
    applyStimulus(2'b01, 2'b00);
    waitDrain("drain_f", 200);
    checkOutput("midwait_next_reload", 512'(reloadCount - rc), 512'(1));

    // Core busy held in REQ: exactly one request, on the first idle cycle.
    forceBusy = 1'b1;
    rq = reqCount;
    applyStimulus(2'b10, 2'b00);
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (coreIf.core_req) seen++;
    end
    checkOutput("busy_hold_no_req", 512'(seen), 512'(0));
    forceBusy = 1'b0;
    @(negedge clk);
    checkOutput("busy_release_req", 512'(coreIf.core_req), 512'(1));
    waitDrain("drain_busy", 200);
    checkOutput("busy_req_once", 512'(reqCount - rq), 512'(1));

    // Reset in WAIT drops the block and the other pending request.
    applyStimulus(2'b01, 2'b00);
    waitCoreReq("rstwait_core_req");
    repeat (3) @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    req = '0;
    checkOutput("rstwait_pend1", 512'(busy[1]), 512'(1));
    rstn = 1'b0;
    expQ0.delete();
    @(negedge clk);
    checkOutput("rstwait_grant", 512'(grant), 512'(0));
    checkOutput("rstwait_busy", 512'(busy), 512'(0));
    checkOutput("rstwait_ks", ks, 512'(0));
    checkOutput("rstwait_core_req", 512'(coreIf.core_req), 512'(0));
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    rc = reloadCount;
    applyStimulus(2'b01, 2'b00);
    waitDrain("drain_rst", 200);
    checkOutput("rstwait_reload", 512'(reloadCount - rc), 512'(1));

    // Watchdog on the instance whose core never answers.
    toReq = 2'b01;
    @(negedge clk);
    toReq = '0;
    c = 0;
    while (toIf.core_req !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    checkOutput("to_core_req", 512'(toIf.core_req), 512'(1));
    c = 0;
    while (toErr === '0 && c < 100) begin @(negedge clk); c++; end
    checkOutput("to_cycles", 512'(c), 512'(TO));
    checkOutput("to_err", 512'(toErr), 512'(2'b01));
    checkOutput("to_grant", 512'(toGrant), 512'(0));
    @(negedge clk);
    checkOutput("to_err_pulse", 512'(toErr), 512'(0));
    toReq = 2'b01;
    @(negedge clk);
    toReq = '0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (toIf.core_key_reload) seen++;
    end
    checkOutput("to_next_reload", 512'(seen), 512'(1));

    // Randomized traffic with key changes and core stalls.
    for (int k = 0; k < 500; k++) begin
      forceBusy = ($urandom_range(0, 7) == 0);
      m = '0;
      l = '0;
      for (int i = 0; i < N; i++) begin
        if ((i == 0 ? expQ0.size() : expQ1.size()) == 0 && $urandom_range(0, 3) == 0) begin
          m[i]   = 1'b1;
          ctr[i] = $urandom;
          if ($urandom_range(0, 2) == 0) begin
            key[i]   = rand256();
            nonce[i] = {$urandom, $urandom, $urandom};
            l[i]     = 1'b1;
          end
        end
      end
      if (m != '0) applyStimulus(m, l);
      else @(negedge clk);
    end
    forceBusy = 1'b0;
    waitDrain("drain_random", 2000);

    $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
    $finish;
  end
endmodule
